// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, FSM/update encodings, state layout and GF(2^8) helpers
package aes_pkg;
   localparam logic       AES_128_BIT_KEY = 1'b0;
   localparam logic       AES_256_BIT_KEY = 1'b1;
   localparam logic [3:0] AES128_ROUNDS   = 4'd10;
   localparam logic [3:0] AES256_ROUNDS   = 4'd14;

   typedef enum logic [1:0] {CTRL_IDLE, CTRL_INIT, CTRL_SBOX, CTRL_MAIN} ctrl_t;
   typedef enum logic [2:0] {NO_UPDATE, INIT_UPDATE, SBOX_UPDATE, MAIN_UPDATE, FINAL_UPDATE} update_t;

   // [column][row][bit]; column 0 / row 0 sit in the most significant byte
   typedef logic [0:3][0:3][7:0] state_t;

   function automatic logic [7:0] gm2(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm3(input logic [7:0] b);
      return gm2(b) ^ b;
   endfunction
endpackage

// File: rtl/aes_encipher_block_if.sv
// aes_encipher_block_if: request/result and key-memory signals of the encipher block
interface aes_encipher_block_if;
   logic         next;
   logic         keylen;
   logic [3:0]   round;
   logic [127:0] round_key;
   logic [127:0] block;
   logic [127:0] new_block;
   logic         ready;

   modport master (output next, keylen, round_key, block, input round, new_block, ready);
   modport slave  (input next, keylen, round_key, block, output round, new_block, ready);
endinterface

// File: rtl/aes_sbox.sv
// aes_sbox: forward AES S-box applied to the four bytes of one 32-bit word
module aes_sbox (
   input  logic [31:0] din,
   output logic [31:0] dout
);
   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign dout = {SBOX[din[31:24]], SBOX[din[23:16]], SBOX[din[15:8]], SBOX[din[7:0]]};
endmodule

// File: rtl/aes_encipher_block.sv
// aes_encipher_block: iterative word-serial AES-128/256 encipher round datapath
module aes_encipher_block
   import aes_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset_n,
   aes_encipher_block_if.slave  bus
);
   ctrl_t       ctrl_q, ctrl_d;
   update_t     upd;
   state_t      st_q, st_d;
   logic [1:0]  sword_ctr_q, sword_ctr_d;
   logic [3:0]  round_ctr_q, round_ctr_d;
   logic [3:0]  num_rounds;
   logic        ready_q, ready_d;
   logic [31:0] sbox_out;

   function automatic state_t shiftrows(input state_t s);
      state_t o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[c][r] = s[2'(c + r)][r];
      return o;
   endfunction

   function automatic state_t mixcolumns(input state_t s);
      state_t o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[c][r] = gm2(s[c][r]) ^ gm3(s[c][2'(r + 1)]) ^ s[c][2'(r + 2)] ^ s[c][2'(r + 3)];
      return o;
   endfunction

   function automatic state_t addroundkey(input state_t s, input logic [127:0] k);
      return s ^ k;
   endfunction

   aes_sbox u_sbox (.din(st_q[sword_ctr_q]), .dout(sbox_out));

   assign num_rounds    = (bus.keylen == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;
   assign bus.round     = round_ctr_q;
   assign bus.new_block = st_q;
   assign bus.ready     = ready_q;

   // control: sequence INIT, then per round four SBOX word steps and one MAIN step
   always_comb begin
      ctrl_d      = ctrl_q;
      sword_ctr_d = sword_ctr_q;
      round_ctr_d = round_ctr_q;
      ready_d     = ready_q;
      upd         = NO_UPDATE;
      case (ctrl_q)
         CTRL_IDLE: if (bus.next) begin
            round_ctr_d = '0;
            ready_d     = 1'b0;
            ctrl_d      = CTRL_INIT;
         end
         CTRL_INIT: begin
            upd         = INIT_UPDATE;
            round_ctr_d = 4'd1;
            sword_ctr_d = '0;
            ctrl_d      = CTRL_SBOX;
         end
         CTRL_SBOX: begin
            upd         = SBOX_UPDATE;
            sword_ctr_d = sword_ctr_q + 2'd1;
            ctrl_d      = (sword_ctr_q == 2'd3) ? CTRL_MAIN : CTRL_SBOX;
         end
         CTRL_MAIN: begin
            sword_ctr_d = '0;
            if (round_ctr_q < num_rounds) begin
               upd         = MAIN_UPDATE;
               round_ctr_d = round_ctr_q + 4'd1;
               ctrl_d      = CTRL_SBOX;
            end else begin
               upd         = FINAL_UPDATE;
               ready_d     = 1'b1;
               ctrl_d      = CTRL_IDLE;
            end
         end
         default: ctrl_d = CTRL_IDLE;
      endcase
   end

   // datapath: next block words selected by the update type
   always_comb begin
      st_d = st_q;
      case (upd)
         INIT_UPDATE:  st_d = addroundkey(bus.block, bus.round_key);
         SBOX_UPDATE:  st_d[sword_ctr_q] = sbox_out;
         MAIN_UPDATE:  st_d = addroundkey(mixcolumns(shiftrows(st_q)), bus.round_key);
         FINAL_UPDATE: st_d = addroundkey(shiftrows(st_q), bus.round_key);
         default:      st_d = st_q;
      endcase
   end

   // state registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_q      <= CTRL_IDLE;
         st_q        <= '0;
         sword_ctr_q <= '0;
         round_ctr_q <= '0;
         ready_q     <= 1'b1;
      end else begin
         ctrl_q      <= ctrl_d;
         st_q        <= st_d;
         sword_ctr_q <= sword_ctr_d;
         round_ctr_q <= round_ctr_d;
         ready_q     <= ready_d;
      end
   end
endmodule

// File: tb/tb_aes_encipher_block.sv
// tb_aes_encipher_block: FIPS-197 known-answer, timing, busy, back-to-back and reset checks
module tb_aes_encipher_block;
   typedef struct {
      logic [255:0] key;
      logic         kl;
      logic [127:0] pt;
      logic [127:0] ct;
   } vec_t;

   localparam logic [7:0] SB [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [127:0] rk [16];
   int           pass = 0;
   int           total = 0;
   vec_t         vecs [3];

   aes_encipher_block_if bus ();

   aes_encipher_block dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   always #5 clk = ~clk;

   // key memory model: round key for the presented round index, zero latency
   assign bus.round_key = rk[bus.round];

   function automatic logic [31:0] subw(input logic [31:0] x);
      return {SB[x[31:24]], SB[x[23:16]], SB[x[15:8]], SB[x[7:0]]};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) pass++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   task automatic expand(input logic [255:0] key, input logic kl);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc;
      int nk, nw;
      nk = kl ? 8 : 4;
      nw = kl ? 60 : 44;
      rc = 8'h01;
      for (int i = 0; i < 60; i++) w[i] = '0;
      for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
      for (int i = nk; i < nw; i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end else if (nk == 8 && i % nk == 4) t = subw(t);
         w[i] = w[i-nk] ^ t;
      end
      for (int r = 0; r < 16; r++) begin
         rk[r] = '0;
         if (4*r + 3 < nw) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      end
   endtask

   // called just after edge E; follows the operation to completion checking the round index
   task automatic wait_done(input int nr, input bit hold, input bit pulse, output int cyc, output bit rok);
      int er;
      cyc = 0;
      rok = 1'b1;
      @(negedge clk);
      bus.next = hold;
      if (bus.round !== 4'd0 || bus.ready !== 1'b0) rok = 1'b0;
      while (bus.ready !== 1'b1 && cyc < 200) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         bus.next = hold || (pulse && (cyc == 4 || cyc == 29));
         er = (cyc - 1) / 5 + 1;
         if (er > nr) er = nr;
         if (bus.round !== 4'(er)) rok = 1'b0;
      end
   endtask

   // called at a negedge; issues next and checks ciphertext, latency and round sequence
   task automatic run_vec(input vec_t v, input bit hold, input bit pulse, input string tag);
      int cyc, nr;
      bit rok;
      nr = v.kl ? 14 : 10;
      expand(v.key, v.kl);
      bus.keylen = v.kl;
      bus.block  = v.pt;
      bus.next   = 1'b1;
      @(posedge clk);
      wait_done(nr, hold, pulse, cyc, rok);
      chk({tag, "_ct"}, bus.new_block, v.ct);
      chk({tag, "_latency"}, 128'(cyc), 128'(5*nr + 1));
      chk({tag, "_round_seq"}, 128'(rok), 128'(1));
   endtask

   initial begin
      logic [127:0] held;
      vecs[0] = '{key: {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, kl: 1'b0,
                  pt: 128'h3243f6a8885a308d313198a2e0370734, ct: 128'h3925841d02dc09fbdc118597196a0b32};
      vecs[1] = '{key: {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, kl: 1'b0,
                  pt: 128'h00112233445566778899aabbccddeeff, ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
      vecs[2] = '{key: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, kl: 1'b1,
                  pt: 128'h00112233445566778899aabbccddeeff, ct: 128'h8ea2b7ca516745bfeafc49904b496089};
      bus.next   = 1'b0;
      bus.keylen = 1'b0;
      bus.block  = '0;
      expand(vecs[0].key, 1'b0);
      repeat (2) @(negedge clk);
      chk("rst_ready", 128'(bus.ready), 128'(1));
      chk("rst_round", 128'(bus.round), 128'(0));
      chk("rst_new_block", bus.new_block, 128'h0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_ready", 128'(bus.ready), 128'(1));
      for (int i = 0; i < 3; i++) run_vec(vecs[i], 1'b0, 1'b0, $sformatf("vec%0d", i));
      held = bus.new_block;
      repeat (5) @(negedge clk);
      chk("idle_stable", bus.new_block, held);
      chk("idle_round", 128'(bus.round), 128'(14));
      run_vec(vecs[0], 1'b0, 1'b1, "busy_next");
      run_vec(vecs[0], 1'b1, 1'b0, "b2b_first");
      run_vec(vecs[2], 1'b0, 1'b0, "b2b_second");
      expand(vecs[0].key, 1'b0);
      bus.keylen = 1'b0;
      bus.block  = vecs[0].pt;
      bus.next   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.next = 1'b0;
      repeat (19) @(posedge clk);
      #3;
      chk("mid_busy", 128'(bus.ready), 128'(0));
      reset_n = 1'b0;
      #1;
      chk("mid_rst_ready", 128'(bus.ready), 128'(1));
      chk("mid_rst_new_block", bus.new_block, 128'h0);
      chk("mid_rst_round", 128'(bus.round), 128'(0));
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      run_vec(vecs[0], 1'b0, 1'b0, "post_rst");
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
